// File: rtl/sdram_pattern_tester.sv
// Memory self-test master: writes a seeded 16-bit pattern over a word range, reads it back,
// and reports pass/fail, a saturating error count and the first failing address.
module sdram_pattern_tester #(
    parameter logic [24:0] START_ADDR    = 25'h0,
    parameter int unsigned NUM_WORDS     = 256,
    parameter int unsigned RD_SAMPLE_DLY = 1,
    parameter int unsigned RD_TIMEOUT    = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] error_count,
    output logic [24:0] first_err_addr,
    output logic        chipselect,
    output logic        write_n,
    output logic        read_n,
    output logic [1:0]  byteenable_n,
    output logic [24:0] address,
    output logic [15:0] write_data,
    input  logic [15:0] read_data,
    input  logic        wait_request,
    input  logic        data_validation
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_READ_SAMPLE,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [16:0] LAST_IDX = 17'(NUM_WORDS - 1);
    localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

    function automatic logic [15:0] pattern(input logic [15:0] s, input logic [15:0] i);
        return (s ^ {i[7:0], i[15:8]}) + i;
    endfunction

    state_t      state;
    logic [16:0] idx;
    logic [15:0] seed_q;
    logic [15:0] rd_q;
    logic [15:0] tmo_cnt;
    logic        miss;
    logic        bad;

    // A timeout counts as a failure regardless of whatever stale data sits in rd_q.
    assign bad = miss || (rd_q != pattern(seed_q, idx[15:0]));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            seed_q         <= '0;
            rd_q           <= '0;
            tmo_cnt        <= '0;
            miss           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            chipselect     <= 1'b0;
            write_n        <= 1'b1;
            read_n         <= 1'b1;
            byteenable_n   <= 2'b11;
            address        <= '0;
            write_data     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        seed_q         <= seed;
                        error_count    <= '0;
                        first_err_addr <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        idx            <= '0;
                        chipselect     <= 1'b1;
                        write_n        <= 1'b0;
                        byteenable_n   <= 2'b00;
                        address        <= START_ADDR;
                        write_data     <= pattern(seed, 16'h0);
                        state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!wait_request) begin
                        if (idx == LAST_IDX) begin
                            idx     <= '0;
                            write_n <= 1'b1;
                            read_n  <= 1'b0;
                            address <= START_ADDR;
                            state   <= S_READ_REQ;
                        end else begin
                            idx        <= idx + 17'd1;
                            address    <= address + 25'd1;
                            write_data <= pattern(seed_q, idx[15:0] + 16'd1);
                        end
                    end
                end
                S_READ_REQ: begin
                    if (!wait_request) begin
                        chipselect   <= 1'b0;
                        read_n       <= 1'b1;
                        byteenable_n <= 2'b11;
                        tmo_cnt      <= '0;
                        state        <= S_READ_WAIT;
                    end
                end
                S_READ_WAIT: begin
                    if (data_validation) begin
                        miss <= 1'b0;
                        if (RD_SAMPLE_DLY == 0) begin
                            rd_q  <= read_data;
                            state <= S_COMPARE;
                        end else begin
                            state <= S_READ_SAMPLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        miss  <= 1'b1;
                        state <= S_COMPARE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_READ_SAMPLE: begin
                    rd_q  <= read_data;
                    state <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (bad) begin
                        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                        if (error_count == 16'h0) first_err_addr <= address;
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (error_count == 16'h0) && !bad;
                        state <= S_DONE;
                    end else begin
                        idx          <= idx + 17'd1;
                        address      <= address + 25'd1;
                        chipselect   <= 1'b1;
                        read_n       <= 1'b0;
                        byteenable_n <= 2'b00;
                        state        <= S_READ_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Self-checking bench: two tester instances (base address 0 and a wrapping base) share one
// behavioural SDRAM responder; results are checked against a pattern/error model.
module tb_sdram_pattern_tester;

    localparam int unsigned NW      = 16;
    localparam logic [24:0] START_B = 25'h1FFFFFE;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, start, sel;
    logic [15:0] seed, read_data;
    logic        wait_request, data_validation;

    logic        busy_a, done_a, pass_a, cs_a, wn_a, rn_a;
    logic [15:0] ec_a, wd_a;
    logic [24:0] fe_a, addr_a;
    logic [1:0]  be_a;
    logic        busy_b, done_b, pass_b, cs_b, wn_b, rn_b;
    logic [15:0] ec_b, wd_b;
    logic [24:0] fe_b, addr_b;
    logic [1:0]  be_b;

    logic        start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    sdram_pattern_tester #(.START_ADDR(25'h0), .NUM_WORDS(NW), .RD_SAMPLE_DLY(1), .RD_TIMEOUT(255)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .seed(seed),
        .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(ec_a), .first_err_addr(fe_a),
        .chipselect(cs_a), .write_n(wn_a), .read_n(rn_a), .byteenable_n(be_a),
        .address(addr_a), .write_data(wd_a), .read_data(read_data),
        .wait_request(wait_request), .data_validation(data_validation)
    );

    sdram_pattern_tester #(.START_ADDR(START_B), .NUM_WORDS(NW), .RD_SAMPLE_DLY(0), .RD_TIMEOUT(255)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .seed(seed),
        .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(ec_b), .first_err_addr(fe_b),
        .chipselect(cs_b), .write_n(wn_b), .read_n(rn_b), .byteenable_n(be_b),
        .address(addr_b), .write_data(wd_b), .read_data(read_data),
        .wait_request(wait_request), .data_validation(data_validation)
    );

    logic        busy, done, pass, cs, wn, rn;
    logic [15:0] ec, wd;
    logic [24:0] fe, addr;
    logic [1:0]  be;
    assign busy = sel ? busy_b : busy_a;
    assign done = sel ? done_b : done_a;
    assign pass = sel ? pass_b : pass_a;
    assign ec   = sel ? ec_b   : ec_a;
    assign fe   = sel ? fe_b   : fe_a;
    assign cs   = sel ? cs_b   : cs_a;
    assign wn   = sel ? wn_b   : wn_a;
    assign rn   = sel ? rn_b   : rn_a;
    assign be   = sel ? be_b   : be_a;
    assign addr = sel ? addr_b : addr_a;
    assign wd   = sel ? wd_b   : wd_a;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pattern straight from the rule: (seed xor byte-swapped index) plus index, mod 2^16.
    function automatic logic [15:0] pat(input logic [15:0] s, input int unsigned i);
        int unsigned sw;
        sw = ((i % 256) * 256) + ((i / 256) % 256);
        return 16'(((32'(s) ^ sw) + i) % 65536);
    endfunction

    function automatic logic [24:0] word_addr(input bit b, input int unsigned i);
        int unsigned st;
        st = b ? 32'(START_B) : 0;
        return 25'((st + i) % 33554432);
    endfunction

    typedef struct {
        bit          sel;
        logic [15:0] seed;
        bit          stuck;
        bit          bp;
        bit          drop;
        int unsigned drop_idx;
        int unsigned poke;
        logic [15:0] exp_err;
        logic [24:0] exp_first;
        bit          exp_pass;
    } vec_t;

    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   bad;
        r = v;
        r.exp_err = 0;
        r.exp_first = 0;
        for (int unsigned i = 0; i < NW; i++) begin
            bad = (v.stuck && pat(v.seed, i)[3]) || (v.drop && i == v.drop_idx);
            if (bad) begin
                if (r.exp_err == 0) r.exp_first = word_addr(v.sel, i);
                r.exp_err++;
            end
        end
        r.exp_pass = (r.exp_err == 0);
        return r;
    endfunction

    // Behavioural SDRAM: memory map, 3-cycle read latency, data held for two cycles from valid.
    bit          bp_en, stuck_en, drop_en;
    logic [24:0] drop_addr;
    logic [15:0] mem [logic [24:0]];
    logic [24:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [24:0] rd_addr_q[$];
    int unsigned rd_cyc_q[$];
    int unsigned stall_viol, cyc;

    initial begin
        int          rsp;
        int          hold;
        logic [15:0] rsp_data;
        bit          prev_stall;
        logic [70:0] snap, prev_snap;
        wait_request = 1'b0; data_validation = 1'b0; read_data = 16'hDEAD;
        rsp = -1; hold = 0; rsp_data = '0; prev_stall = 0; prev_snap = '0;
        cyc = 0; stall_viol = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                rsp = -1; hold = 0; prev_stall = 0;
                data_validation = 1'b0; wait_request = 1'b0; read_data = 16'hDEAD;
            end else begin
                snap = {cs, wn, rn, be, addr, wd};
                if (prev_stall && snap !== prev_snap) stall_viol++;
                data_validation = 1'b0;
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) read_data = 16'hDEAD;
                end
                if (rsp > 0) begin
                    rsp--;
                    if (rsp == 0) begin
                        data_validation = 1'b1;
                        read_data = rsp_data;
                        hold = 2;
                        rsp = -1;
                    end
                end
                wait_request = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
                if (cs && !wait_request) begin
                    if (!wn) begin
                        wr_addr_q.push_back(addr);
                        wr_data_q.push_back(wd);
                        mem[addr] = wd;
                    end else if (!rn) begin
                        rd_addr_q.push_back(addr);
                        rd_cyc_q.push_back(cyc);
                        if (!(drop_en && addr == drop_addr)) begin
                            rsp = 3;
                            rsp_data = (mem.exists(addr) ? mem[addr] : 16'h0) & (stuck_en ? 16'hFFF7 : 16'hFFFF);
                        end
                    end
                end
                prev_stall = cs && wait_request;
                prev_snap = snap;
            end
        end
    end

    localparam logic [89:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 25'h0};

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned n, bad_w, bad_r, j;
        sel = v.sel; bp_en = v.bp; stuck_en = v.stuck; drop_en = v.drop;
        drop_addr = word_addr(v.sel, v.drop_idx);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
        stall_viol = 0;
        @(negedge clock);
        seed = v.seed; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, "_start"}, {busy, cs, wn, done, pass, ec, fe}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 25'h0});
        n = 0;
        while (!done && n < 8000) begin
            @(negedge clock);
            n++;
            if (v.poke != 0 && n == v.poke) begin seed = ~v.seed; start = 1'b1; end
            else start = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_done"}, {done, busy}, {1'b1, 1'b0});
        chk({tag, "_result"}, {pass, ec, fe}, {v.exp_pass, v.exp_err, v.exp_first});
        bad_w = 0;
        for (int unsigned i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== word_addr(v.sel, i) || wr_data_q[i] !== pat(v.seed, i)) bad_w++;
        chk({tag, "_writes"}, {wr_addr_q.size(), bad_w}, {NW, 32'd0});
        bad_r = 0;
        for (int unsigned i = 0; i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] !== word_addr(v.sel, i)) bad_r++;
        chk({tag, "_reads"}, {rd_addr_q.size(), bad_r}, {NW, 32'd0});
        chk({tag, "_stall_stable"}, stall_viol, 0);
        if (v.drop && rd_cyc_q.size() > v.drop_idx + 1) begin
            j = rd_cyc_q[v.drop_idx + 1] - rd_cyc_q[v.drop_idx];
            chk({tag, "_timeout_gap_ok"}, (j >= 255 && j <= 262), 1);
        end
    endtask

    initial begin
        vec_t vecs[7];
        reset_n = 1'b0; start = 1'b0; seed = 16'h0; sel = 1'b0;
        bp_en = 0; stuck_en = 0; drop_en = 0; drop_addr = '0;

        vecs[0] = '{sel:0, seed:16'hA5A5, stuck:0, bp:0, drop:0, drop_idx:0, poke:0, exp_err:0, exp_first:0, exp_pass:0};
        vecs[1] = '{sel:0, seed:16'hA5A5, stuck:1, bp:0, drop:0, drop_idx:0, poke:0, exp_err:0, exp_first:0, exp_pass:0};
        vecs[2] = '{sel:0, seed:16'hA5A5, stuck:0, bp:1, drop:0, drop_idx:0, poke:0, exp_err:0, exp_first:0, exp_pass:0};
        vecs[3] = '{sel:1, seed:16'($urandom), stuck:0, bp:0, drop:1, drop_idx:5, poke:0, exp_err:0, exp_first:0, exp_pass:0};
        vecs[4] = '{sel:0, seed:16'($urandom), stuck:1, bp:1, drop:0, drop_idx:0, poke:0, exp_err:0, exp_first:0, exp_pass:0};
        vecs[5] = '{sel:1, seed:16'($urandom), stuck:0, bp:1, drop:0, drop_idx:0, poke:5, exp_err:0, exp_first:0, exp_pass:0};
        vecs[6] = '{sel:0, seed:16'h5A5A, stuck:1, bp:0, drop:0, drop_idx:0, poke:40, exp_err:0, exp_first:0, exp_pass:0};
        for (int i = 0; i < 7; i++) vecs[i] = model(vecs[i]);

        repeat (3) @(negedge clock);
        chk("reset_a", {cs_a, wn_a, rn_a, be_a, addr_a, wd_a, busy_a, done_a, pass_a, ec_a, fe_a}, RESET_VEC);
        chk("reset_b", {cs_b, wn_b, rn_b, be_b, addr_b, wd_b, busy_b, done_b, pass_b, ec_b, fe_b}, RESET_VEC);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0 && wr_data_q.size() > 0)
                chk("vec0_word0", {wr_addr_q[0], wr_data_q[0]}, {25'h0, 16'hA5A5});
            if (i == 3)
                chk("vec3_wrap_addr", {wr_addr_q.size() > 2 ? {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]} : 75'h0},
                    {25'h1FFFFFE, 25'h1FFFFFF, 25'h0});
        end

        // Reset mid-write under backpressure, then a start pulse while reset is still low.
        sel = 1'b0; bp_en = 1; stuck_en = 0; drop_en = 0;
        @(negedge clock);
        seed = 16'h1234; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("midwrite_busy", {busy_a, cs_a}, {1'b1, 1'b1});
        reset_n = 1'b0;
        #1;
        chk("async_reset_a", {cs_a, wn_a, rn_a, be_a, addr_a, wd_a, busy_a, done_a, pass_a, ec_a, fe_a}, RESET_VEC);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("start_in_reset_lost", {busy_a, cs_a, done_a}, {1'b0, 1'b0, 1'b0});

        // Clean rerun after a failing run clears the earlier results.
        run_vec(vecs[1], "rerun_fail");
        run_vec(vecs[0], "rerun_clean");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
